// File: rtl/ram_sdp_clr_if.sv
// Port bundle for ram_sdp_clr: write port, read port, clear request and status.
interface ram_sdp_clr_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  clr;
    logic                  busy;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] wraddress;
    logic [DATA_WIDTH-1:0] data;
    logic [NB-1:0]         byteena;
    logic                  rden;
    logic [ADDR_WIDTH-1:0] rdaddress;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;

    modport master (
        output clr, wren, wraddress, data, byteena, rden, rdaddress,
        input  busy, q, q_valid
    );

    modport slave (
        input  clr, wren, wraddress, data, byteena, rden, rdaddress,
        output busy, q, q_valid
    );
endinterface

// File: rtl/ram_sdp_clr.sv
// Single-clock simple dual-port RAM with byte enables, write-first bypass,
// selectable read latency and a hardware clear engine that sweeps the array.
module ram_sdp_clr #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 4,
    parameter int unsigned            BYTE_WIDTH = 8,
    parameter int unsigned            OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0]  CLR_VALUE  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_sdp_clr_if.slave bus
);
    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  busy_r;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] q1;
    logic                  v1;

    assign wr_acc   = bus.wren & ~busy_r;
    assign rd_acc   = bus.rden & ~busy_r;
    assign bus.busy = busy_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            busy_r <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (bus.clr) begin
                        state  <= S_CLEAR;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_CLEAR;
                    cnt    <= '0;
                    busy_r <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy_r) begin
            mem[cnt] <= CLR_VALUE;
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.byteena[i]) begin
                    mem[bus.wraddress][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first: enabled lanes of a same-address write replace the stored lanes.
    always_comb begin
        rd_word = mem[bus.rdaddress];
        if (wr_acc && (bus.wraddress == bus.rdaddress)) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.byteena[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                q1 <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2;
            logic                  v2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        q2 <= q1;
                    end
                end
            end

            assign bus.q       = q2;
            assign bus.q_valid = v2;
        end else begin : g_no_out_reg
            assign bus.q       = q1;
            assign bus.q_valid = v1;
        end
    endgenerate
endmodule

// File: tb/tb_ram_sdp_clr.sv
// Scoreboard bench for ram_sdp_clr: drives two instances (latency 1 and 2)
// with identical stimulus and checks data, latency and clear behaviour.
module tb_ram_sdp_clr;
    localparam logic [31:0] CLRV = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] d;
        int unsigned c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] model [16];
    exp_t        sb0 [$];
    exp_t        sb1 [$];

    ram_sdp_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8)) bus0 ();
    ram_sdp_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8)) bus1 ();

    ram_sdp_clr #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(0), .CLR_VALUE(CLRV)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    ram_sdp_clr #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(1), .CLR_VALUE(CLRV)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit wr, input logic [3:0] wa, input logic [31:0] wd,
                          input logic [3:0] be, input bit rd, input logic [3:0] ra, input bit c);
        bus0.wren = wr; bus0.wraddress = wa; bus0.data = wd; bus0.byteena = be;
        bus0.rden = rd; bus0.rdaddress = ra; bus0.clr = c;
        bus1.wren = wr; bus1.wraddress = wa; bus1.data = wd; bus1.byteena = be;
        bus1.rden = rd; bus1.rdaddress = ra; bus1.clr = c;
    endtask

    // One clock of stimulus; when acc is set the bench expects the ports to be live.
    task automatic op(input bit wr, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input bit rd, input logic [3:0] ra,
                      input bit c, input bit acc);
        logic [31:0] e;
        exp_t        x;
        set_in(wr, wa, wd, be, rd, ra, c);
        if (acc) begin
            if (rd) begin
                e = model[ra];
                if (wr && wa == ra)
                    for (int i = 0; i < 4; i++)
                        if (be[i]) e[i*8 +: 8] = wd[i*8 +: 8];
                x.d = e;
                x.c = cyc + 1;
                sb0.push_back(x);
                x.c = cyc + 2;
                sb1.push_back(x);
            end
            if (wr)
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[wa][i*8 +: 8] = wd[i*8 +: 8];
        end
        @(posedge clk);
        #1;
        set_in(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_clear(input string tag, input bit poke, output bit qnz);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        qnz = 1'b0;
        while (!done && n < 64) begin
            if (poke && n < 3) set_in(1'b1, 4'd7, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd7, 1'b1);
            @(posedge clk);
            #1;
            set_in(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
            n++;
            if (bus0.q != 0 || bus1.q != 0) qnz = 1'b1;
            if (!bus0.busy) done = 1'b1;
        end
        check({tag, "_len"}, n, 16);
        check({tag, "_busy1"}, {31'b0, bus1.busy}, 32'd0);
        for (int i = 0; i < 16; i++) model[i] = CLRV;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) op(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0, 1'b1);
        drain();
    endtask

    task automatic preload();
        for (int a = 0; a < 16; a++) op(1'b1, 4'(a), 32'(a), 4'hF, 1'b0, '0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (bus0.q_valid) begin
            if (sb0.size() == 0) check("spur0", 32'd1, 32'd0);
            else begin
                x = sb0.pop_front();
                check("q0", bus0.q, x.d);
                check("lat0", cyc, x.c);
            end
        end
        if (bus1.q_valid) begin
            if (sb1.size() == 0) check("spur1", 32'd1, 32'd0);
            else begin
                x = sb1.pop_front();
                check("q1", bus1.q, x.d);
                check("lat1", cyc, x.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit qnz;
        set_in(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) model[i] = 'x;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus0.busy}, 32'd1);
        check("rst_q0", bus0.q, 32'd0);
        check("rst_q1", bus1.q, 32'd0);
        check("rst_v", {30'b0, bus1.q_valid, bus0.q_valid}, 32'd0);
        rst_n = 1'b1;
        wait_clear("rst", 1'b0, qnz);
        check("rst_qhold", {31'b0, qnz}, 32'd0);
        read_all();

        // Byte lanes, then a byteena=0 no-op, then q holding while idle
        op(1'b1, 4'd5, 32'h0, 4'hF, 1'b0, '0, 1'b0, 1'b1);
        op(1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b0, '0, 1'b0, 1'b1);
        op(1'b1, 4'd5, 32'hFFFFFFFF, 4'b0000, 1'b0, '0, 1'b0, 1'b1);
        op(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0, 1'b1);
        drain();
        check("hold0", bus0.q, 32'h00220044);
        check("hold1", bus1.q, 32'h00220044);

        op(1'b1, 4'd3, 32'hAAAAAAAA, 4'hF, 1'b0, '0, 1'b0, 1'b1);
        op(1'b1, 4'd3, 32'h55555555, 4'b1100, 1'b1, 4'd3, 1'b0, 1'b1);
        drain();
        check("bypass0", bus0.q, 32'h5555AAAA);

        preload();
        read_all();

        // clr sampled with a read in the same cycle; then accesses and clr while busy
        op(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1, 1'b1);
        wait_clear("clr", 1'b1, qnz);
        read_all();

        preload();
        op(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", {31'b0, bus0.busy}, 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear("midrst", 1'b0, qnz);
        read_all();

        check("sb0_empty", sb0.size(), 32'd0);
        check("sb1_empty", sb1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_sdp_clr.md
# ram_sdp_clr

Parametrised single-clock simple dual-port RAM: one write port and one read port. It adds four things: per-byte write enables, a selectable read latency (1 or 2 cycles) with a `q_valid` strobe, write-first bypass on same-address collisions, and a hardware clear engine. The clear engine fills the whole array with a constant after reset and whenever `clr` is pulsed. It is the general-purpose buffer memory for the memory subsystem and replaces fixed-size dual-clock RAMs wherever both ports share one clock.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width in bits; must be a multiple of `BYTE_WIDTH`.
- `ADDR_WIDTH`, 4, address width; depth = 2**ADDR_WIDTH.
- `BYTE_WIDTH`, 8, bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- `OUT_REG`, 0, 0 = read latency 1, 1 = extra output register, read latency 2.
- `CLR_VALUE`, 0, DATA_WIDTH-wide word written to every location by the clear engine.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `clr` in 1: request a full-array clear; sampled only when `busy`=0.
- `busy` out 1: high while the clear engine runs; ports are ignored while high.
- `wren` in 1: write enable.
- `wraddress` in ADDR_WIDTH: write address.
- `data` in DATA_WIDTH: write data.
- `byteena` in NB: per-lane write enable; bit i covers `data[i*BYTE_WIDTH +: BYTE_WIDTH]`.
- `rden` in 1: read enable.
- `rdaddress` in ADDR_WIDTH: read address.
- `q` out DATA_WIDTH: read data.
- `q_valid` out 1: one-cycle strobe marking `q` as the result of an accepted read.

## Operation
- Two-state FSM:
  - CLEAR: `busy`=1. Each cycle writes CLR_VALUE to `ram[cnt]`, then cnt++. After writing address 2**ADDR_WIDTH-1 it moves to IDLE.
  - IDLE: `busy`=0. If `clr`=1, moves to CLEAR with cnt=0.
- Reset state:
  - FSM is in CLEAR with cnt=0 and `busy`=1.
  - `q`=0, `q_valid`=0; the output pipeline stage is 0 and invalid.
  - Array contents are not reset directly; the clear engine initialises them.
- Reset asserted mid-clear aborts the sweep; the sweep restarts from address 0 after release.
- `clr` during CLEAR is ignored; the sweep does not restart.
- Write accepted when `wren`=1 and `busy`=0. Only lanes with `byteena[i]`=1 are updated. `byteena`=0 is a no-op.
- Read accepted when `rden`=1 and `busy`=0. `wren`/`rden` while `busy`=1 are dropped, with no `q_valid` and no array change.
- Collision: an accepted read and an accepted write to the same address in the same cycle return the new data (write-first).
  - Enabled lanes come from `data`; disabled lanes come from the old contents.
- The cycle in which `clr` is sampled in IDLE still performs that cycle's accepted read and write. The clear starts the next cycle, and its output still emerges with `q_valid`.
- `q` holds its last value when no read is accepted. `q_valid` is 0 in every cycle without a completing read.
- Back-to-back reads are fully pipelined: one accepted read per cycle gives one `q_valid` per cycle.

## Timing
- Clear duration:
  - After `rst_n` rises, edges 1..2**ADDR_WIDTH write addresses 0..2**ADDR_WIDTH-1.
  - `busy` falls on edge 2**ADDR_WIDTH.
  - The first port access is accepted on edge 2**ADDR_WIDTH+1.
- `clr` pulse: `clr` is sampled high at edge k; `busy`=1 from edge k until edge k+2**ADDR_WIDTH, when it falls.
- Read latency with OUT_REG=0: read accepted at edge k gives `q` and `q_valid`=1 after edge k, for one cycle.
- Read latency with OUT_REG=1: `q` and `q_valid` are valid after edge k+1.
- Write to read: a write at edge k is visible to a read accepted at edge k (bypass) and at any later edge.

## Test plan
- Reset and clear:
  - Stimulus: release `rst_n` with ADDR_WIDTH=4, CLR_VALUE=32'hDEADBEEF.
  - Response: `busy`=1 for exactly 16 edges, `q`=0 and `q_valid`=0 throughout. Reads of addresses 0..15 then return 32'hDEADBEEF.
- Byte-enable write:
  - Stimulus: after clear to 0, write 32'h11223344 to address 5 with `byteena`=4'b0101, then read address 5.
  - Response: `q`=32'h00220044, `q_valid` high one cycle after the read (two with OUT_REG=1).
- Collision bypass:
  - Stimulus: address 3 holds 32'hAAAAAAAA. In the same cycle, write 32'h55555555 with `byteena`=4'b1100 and read address 3.
  - Response: `q`=32'h5555AAAA.
- Streaming reads:
  - Stimulus: run 16 consecutive reads of addresses 0..15, with address i preloaded as i.
  - Response: 16 consecutive `q_valid` cycles, `q`=0..15 in order, at the correct latency for each OUT_REG setting.
- Clear while busy and accesses dropped:
  - Stimulus: pulse `clr` in IDLE, then assert `wren` (addr 7, 32'hFFFFFFFF), `rden`, and `clr` again while `busy`=1.
  - Response: no `q_valid` during busy, the sweep is not restarted (busy lasts 16 cycles), and address 7 reads CLR_VALUE afterwards.
- Reset mid-clear:
  - Stimulus: assert `rst_n`=0 on the 6th clear cycle, then release.
  - Response: `busy` stays high a full 16 edges from release, and all addresses read CLR_VALUE.
